// File: rtl/reg_file_write_arbiter.sv
// Two-requester write arbiter in front of a register file: A has priority,
// B is forced through after STARVE_LIMIT consecutive denials. One-cycle write latency.
module reg_file_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SEL_WIDTH    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_a_valid,
  input  logic [SEL_WIDTH-1:0]        req_a_sel,
  input  logic [DATA_WIDTH-1:0]       req_a_data,
  output logic                        req_a_ready,
  input  logic                        req_b_valid,
  input  logic [SEL_WIDTH-1:0]        req_b_sel,
  input  logic [DATA_WIDTH-1:0]       req_b_data,
  output logic                        req_b_ready,
  output logic                        out_write_en,
  output logic [SEL_WIDTH-1:0]        out_write_sel,
  output logic [DATA_WIDTH-1:0]       out_write_data,
  output logic [(2**SEL_WIDTH)-1:0]   busy_mask,
  output logic [3:0]                  starve_count
);

  localparam int unsigned NUM_REGS = 2 ** SEL_WIDTH;
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  grant_a_c;
  logic                  grant_b_c;
  logic                  transfer_c;
  logic [SEL_WIDTH-1:0]  win_sel_c;
  logic [DATA_WIDTH-1:0] win_data_c;
  logic [CNT_W-1:0]      starve_next_c;

  // Grant: B wins when alone or when it has waited STARVE_LIMIT cycles
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (!rst) begin
      grant_b_c = req_b_valid && (!req_a_valid || (starve_count == LIMIT));
      grant_a_c = req_a_valid && !grant_b_c;
    end
  end

  assign req_a_ready = grant_a_c;
  assign req_b_ready = grant_b_c;
  assign transfer_c  = grant_a_c || grant_b_c;

  always_comb begin
    win_sel_c  = grant_b_c ? req_b_sel  : req_a_sel;
    win_data_c = grant_b_c ? req_b_data : req_a_data;
  end

  // Starvation counter: counts denied B cycles, saturates, clears when B idle or served
  always_comb begin
    starve_next_c = starve_count;
    if (!req_b_valid || grant_b_c) begin
      starve_next_c = '0;
    end else if (starve_count < LIMIT) begin
      starve_next_c = starve_count + CNT_W'(1);
    end
  end

  // Output write port; register 0 is accepted but never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_write_en   <= 1'b0;
      out_write_sel  <= '0;
      out_write_data <= '0;
      starve_count   <= '0;
    end else begin
      out_write_en <= transfer_c && (win_sel_c != '0);
      if (transfer_c) begin
        out_write_sel  <= win_sel_c;
        out_write_data <= win_data_c;
      end
      starve_count <= starve_next_c;
    end
  end

  // Hazard mask: pending requests plus the write currently on the port
  always_comb begin
    busy_mask = '0;
    if (!rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if ((req_a_valid && (req_a_sel == SEL_WIDTH'(i))) ||
            (req_b_valid && (req_b_sel == SEL_WIDTH'(i))) ||
            (out_write_en && (out_write_sel == SEL_WIDTH'(i)))) begin
          busy_mask[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Randomized and directed bench for reg_file_write_arbiter against a cycle-level reference model.
module tb_reg_file_write_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a_valid, req_b_valid;
  logic [SW-1:0] req_a_sel, req_b_sel;
  logic [DW-1:0] req_a_data, req_b_data;
  logic          req_a_ready, req_b_ready;
  logic          out_write_en;
  logic [SW-1:0] out_write_sel;
  logic [DW-1:0] out_write_data;
  logic [15:0]   busy_mask;
  logic [3:0]    starve_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic          m_wen   = 1'b0;
  logic [SW-1:0] m_wsel  = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_starve = 0;
  logic          e_a_rdy, e_b_rdy;
  logic [15:0]   e_busy;

  reg_file_write_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_sel(req_a_sel), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_sel(req_b_sel), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
    .out_write_en(out_write_en), .out_write_sel(out_write_sel), .out_write_data(out_write_data),
    .busy_mask(busy_mask), .starve_count(starve_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's requests at the falling edge and predict the combinational outputs
  task automatic apply(input logic av, input logic [SW-1:0] as, input logic [DW-1:0] ad,
                       input logic bv, input logic [SW-1:0] bs, input logic [DW-1:0] bd);
    @(negedge clk);
    req_a_valid = av; req_a_sel = as; req_a_data = ad;
    req_b_valid = bv; req_b_sel = bs; req_b_data = bd;
    e_b_rdy = bv && (!av || (m_starve == int'(LIMIT)));
    e_a_rdy = av && !e_b_rdy;
    e_busy  = '0;
    for (int i = 1; i < 16; i++) begin
      if ((av && int'(as) == i) || (bv && int'(bs) == i) || (m_wen && int'(m_wsel) == i))
        e_busy[i] = 1'b1;
    end
    #1;
  endtask

  // Advance past the rising edge, updating the model with whatever was granted
  task automatic advance();
    if (e_a_rdy) begin
      m_wen = (req_a_sel != 0); m_wsel = req_a_sel; m_wdata = req_a_data;
    end else if (e_b_rdy) begin
      m_wen = (req_b_sel != 0); m_wsel = req_b_sel; m_wdata = req_b_data;
    end else begin
      m_wen = 1'b0;
    end
    if (!req_b_valid || e_b_rdy) m_starve = 0;
    else if (m_starve < int'(LIMIT)) m_starve++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a_valid = 1'b1; req_a_sel = 4'd3; req_a_data = 32'hA5A5_A5A5;
    req_b_valid = 1'b1; req_b_sel = 4'd4; req_b_data = 32'h5A5A_5A5A;
    #1;
    total++; if (out_write_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", out_write_en); end
    total++; if (out_write_sel !== '0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", out_write_sel); end
    total++; if (out_write_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_write_data); end
    total++; if (starve_count !== 4'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", starve_count); end
    repeat (2) @(posedge clk);
    #1;
    total++; if ({req_a_ready, req_b_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {req_a_ready, req_b_ready}); end
    total++; if (busy_mask !== 16'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
    total++; if (out_write_en !== 1'b0) begin bad++; $display("FAIL reset_no_xfer got=%b exp=0", out_write_en); end
    @(negedge clk);
    rst = 1'b0;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    m_wen = 1'b0; m_wsel = '0; m_wdata = '0; m_starve = 0;
  endtask

  task automatic test_a_only();
    apply(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, '0, '0);
    total++; if ({req_a_ready, req_b_ready} !== 2'b10) begin bad++; $display("FAIL a_only_ready got=%b exp=10", {req_a_ready, req_b_ready}); end
    total++; if (busy_mask !== 16'h0008) begin bad++; $display("FAIL a_only_busy got=%h exp=0008", busy_mask); end
    advance();
    total++; if ({out_write_en, out_write_sel, out_write_data} !== {1'b1, 4'd3, 32'hDEAD_BEEF})
      begin bad++; $display("FAIL a_only_write got=%b/%0d/%h exp=1/3/deadbeef", out_write_en, out_write_sel, out_write_data); end
    idle();
    total++; if (out_write_en !== 1'b0) begin bad++; $display("FAIL a_only_drop got=%b exp=0", out_write_en); end
    total++; if ({out_write_sel, out_write_data} !== {4'd3, 32'hDEAD_BEEF})
      begin bad++; $display("FAIL a_only_hold got=%0d/%h exp=3/deadbeef", out_write_sel, out_write_data); end
  endtask

  task automatic test_starvation();
    idle();
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, 4'd1, 32'h0000_00A1, 1'b1, 4'd2, 32'h0000_00B2);
      total++; if (starve_count !== 4'(k % 4)) begin bad++; $display("FAIL starve_cnt k=%0d got=%0d exp=%0d", k, starve_count, k % 4); end
      total++; if ({req_a_ready, req_b_ready} !== ((k % 4 == 3) ? 2'b01 : 2'b10))
        begin bad++; $display("FAIL starve_grant k=%0d got=%b", k, {req_a_ready, req_b_ready}); end
      advance();
      total++; if (out_write_sel !== ((k % 4 == 3) ? 4'd2 : 4'd1))
        begin bad++; $display("FAIL starve_order k=%0d got=%0d", k, out_write_sel); end
    end
    idle();
    total++; if (starve_count !== 4'd0) begin bad++; $display("FAIL starve_clear got=%0d exp=0", starve_count); end
  endtask

  task automatic test_zero_sel();
    apply(1'b0, '0, '0, 1'b1, 4'd0, 32'h0000_1234);
    total++; if (req_b_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", req_b_ready); end
    total++; if (busy_mask !== 16'h0) begin bad++; $display("FAIL zero_busy0 got=%h exp=0", busy_mask); end
    advance();
    total++; if (out_write_en !== 1'b0) begin bad++; $display("FAIL zero_en got=%b exp=0", out_write_en); end
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (busy_mask !== 16'h0) begin bad++; $display("FAIL zero_busy1 got=%h exp=0", busy_mask); end
    advance();
  endtask

  task automatic test_collision();
    idle();
    apply(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22);
    total++; if ({req_a_ready, req_b_ready} !== 2'b10) begin bad++; $display("FAIL coll_grant got=%b exp=10", {req_a_ready, req_b_ready}); end
    total++; if (busy_mask[5] !== 1'b1) begin bad++; $display("FAIL coll_busy_c0 got=%b exp=1", busy_mask[5]); end
    advance();
    total++; if ({out_write_en, out_write_sel, out_write_data} !== {1'b1, 4'd5, 32'h11})
      begin bad++; $display("FAIL coll_first got=%b/%0d/%h exp=1/5/11", out_write_en, out_write_sel, out_write_data); end
    apply(1'b0, '0, '0, 1'b1, 4'd5, 32'h22);
    total++; if (req_b_ready !== 1'b1 || busy_mask[5] !== 1'b1)
      begin bad++; $display("FAIL coll_c1 got rdy=%b busy=%b exp=1/1", req_b_ready, busy_mask[5]); end
    advance();
    total++; if ({out_write_en, out_write_sel, out_write_data} !== {1'b1, 4'd5, 32'h22})
      begin bad++; $display("FAIL coll_second got=%b/%0d/%h exp=1/5/22", out_write_en, out_write_sel, out_write_data); end
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (busy_mask[5] !== 1'b1) begin bad++; $display("FAIL coll_busy_c2 got=%b exp=1", busy_mask[5]); end
    advance();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (busy_mask[5] !== 1'b0) begin bad++; $display("FAIL coll_busy_end got=%b exp=0", busy_mask[5]); end
    advance();
  endtask

  task automatic test_random();
    logic pa, pb;
    logic [SW-1:0] as, bs;
    logic [DW-1:0] ad, bd;
    pa = 1'b0; pb = 1'b0; as = '0; bs = '0; ad = '0; bd = '0;
    for (int n = 0; n < 300; n++) begin
      if (!pa && ($urandom_range(0, 2) != 0)) begin pa = 1'b1; as = SW'($urandom_range(0, 15)); ad = $urandom; end
      if (!pb && ($urandom_range(0, 2) != 0)) begin pb = 1'b1; bs = SW'($urandom_range(0, 15)); bd = $urandom; end
      apply(pa, as, ad, pb, bs, bd);
      total++; if ({req_a_ready, req_b_ready} !== {e_a_rdy, e_b_rdy})
        begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, {req_a_ready, req_b_ready}, {e_a_rdy, e_b_rdy}); end
      total++; if (busy_mask !== e_busy)
        begin bad++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy_mask, e_busy); end
      if (e_a_rdy) pa = 1'b0;
      if (e_b_rdy) pb = 1'b0;
      advance();
      total++; if (out_write_en !== m_wen)
        begin bad++; $display("FAIL rnd_en n=%0d got=%b exp=%b", n, out_write_en, m_wen); end
      if (m_wen) begin
        total++; if ({out_write_sel, out_write_data} !== {m_wsel, m_wdata})
          begin bad++; $display("FAIL rnd_write n=%0d got=%0d/%h exp=%0d/%h", n, out_write_sel, out_write_data, m_wsel, m_wdata); end
      end
      total++; if (starve_count !== 4'(m_starve))
        begin bad++; $display("FAIL rnd_starve n=%0d got=%0d exp=%0d", n, starve_count, m_starve); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    apply(1'b1, 4'd7, 32'h0770_0770, 1'b1, 4'd9, 32'h0990_0990);
    advance();
    total++; if ({out_write_en, out_write_sel, starve_count} !== {1'b1, 4'd7, 4'd1})
      begin bad++; $display("FAIL mid_pre got=%b/%0d/%0d exp=1/7/1", out_write_en, out_write_sel, starve_count); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_write_en !== 1'b0) begin bad++; $display("FAIL mid_en got=%b exp=0", out_write_en); end
    total++; if (starve_count !== 4'd0) begin bad++; $display("FAIL mid_starve got=%0d exp=0", starve_count); end
    total++; if ({req_a_ready, req_b_ready} !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b exp=00", {req_a_ready, req_b_ready}); end
    @(posedge clk); #1;
    total++; if ({req_a_ready, req_b_ready, out_write_en} !== 3'b000)
      begin bad++; $display("FAIL mid_hold got=%b exp=000", {req_a_ready, req_b_ready, out_write_en}); end
    @(negedge clk);
    rst = 1'b0;
    m_wen = 1'b0; m_wsel = '0; m_wdata = '0; m_starve = 0;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    apply(1'b1, 4'd7, 32'h0000_7777, 1'b0, '0, '0);
    total++; if (req_a_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", req_a_ready); end
    advance();
    total++; if ({out_write_en, out_write_sel, out_write_data} !== {1'b1, 4'd7, 32'h0000_7777})
      begin bad++; $display("FAIL post_rst_write got=%b/%0d/%h exp=1/7/7777", out_write_en, out_write_sel, out_write_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_starvation();
    test_zero_sel();
    test_collision();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
